// File: rtl/mult_seq32.sv
// Iterative 32x32->64 shift-add multiplier driving a single adder32.
// Optional signed operands: define MULT_SEQ_SIGNED_EN.

module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carryIn,
  output logic [31:0] result,
  output logic        carryOut,
  output logic        overflow
);

  assign {carryOut, result} = {1'b0, a} + {1'b0, b} + {32'b0, carryIn};
  assign overflow = (a[31] == b[31]) && (result[31] != a[31]);

endmodule

module mult_seq32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MULT_SEQ_SIGNED_EN
  input  logic             signedOp,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultHi,
  output logic [WIDTH-1:0] resultLo,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
`ifdef MULT_SEQ_SIGNED_EN
    FIX  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t state, nstate;

  logic [WIDTH-1:0] m, ph, pl;
  logic [WIDTH-1:0] ph_n, pl_n;
  logic [CNT_W-1:0] cnt;
  logic             last;

  logic [WIDTH-1:0] add_a, add_b, sum;
  logic             add_ci, co;
  logic             add_ov_unused;

  logic [WIDTH-1:0] ma, mb;
  logic             ov_n;

`ifdef MULT_SEQ_SIGNED_EN
  logic sgn, neg, fstep, c;
  logic fix_need;
`endif

  adder32 u_add (
    .a        (add_a),
    .b        (add_b),
    .carryIn  (add_ci),
    .result   (sum),
    .carryOut (co),
    .overflow (add_ov_unused)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Operand capture: magnitudes when a signed multiply is requested
`ifdef MULT_SEQ_SIGNED_EN
  assign ma = (signedOp && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign mb = (signedOp && B[WIDTH-1]) ? (~B + 1'b1) : B;
  assign fix_need = neg && (|{ph_n, pl_n});
`else
  assign ma = A;
  assign mb = B;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (start) nstate = CALC;
      CALC: begin
        if (last) begin
`ifdef MULT_SEQ_SIGNED_EN
          nstate = fix_need ? FIX : DONE;
`else
          nstate = DONE;
`endif
        end
      end
`ifdef MULT_SEQ_SIGNED_EN
      FIX:  if (fstep) nstate = DONE;
`endif
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Adder steering and next partial-product values
  always_comb begin
    add_a  = ph;
    add_b  = pl[0] ? m : '0;
    add_ci = 1'b0;
    ph_n   = ph;
    pl_n   = pl;
    unique case (state)
      CALC: begin
        ph_n = {co, sum[WIDTH-1:1]};
        pl_n = {sum[0], pl[WIDTH-1:1]};
      end
`ifdef MULT_SEQ_SIGNED_EN
      FIX: begin
        add_b = '0;
        if (!fstep) begin
          add_a  = ~pl;
          add_ci = 1'b1;
          pl_n   = sum;
        end else begin
          add_a  = ~ph;
          add_ci = c;
          ph_n   = sum;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
`ifdef MULT_SEQ_SIGNED_EN
    if (sgn) ov_n = (ph_n != {WIDTH{pl_n[WIDTH-1]}});
    else     ov_n = (ph_n != '0);
`else
    ov_n = (ph_n != '0);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m        <= '0;
      ph       <= '0;
      pl       <= '0;
      cnt      <= '0;
      resultHi <= '0;
      resultLo <= '0;
      overflow <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
      sgn      <= 1'b0;
      neg      <= 1'b0;
      fstep    <= 1'b0;
      c        <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start) begin
        m   <= ma;
        ph  <= '0;
        pl  <= mb;
        cnt <= '0;
`ifdef MULT_SEQ_SIGNED_EN
        sgn   <= signedOp;
        neg   <= signedOp && (A[WIDTH-1] ^ B[WIDTH-1]);
        fstep <= 1'b0;
        c     <= 1'b0;
`endif
      end else begin
        ph <= ph_n;
        pl <= pl_n;
        if (state == CALC) cnt <= cnt + 1'b1;
`ifdef MULT_SEQ_SIGNED_EN
        if (state == FIX && !fstep) begin
          fstep <= 1'b1;
          c     <= co;
        end
`endif
      end
      if (nstate == DONE) begin
        resultHi <= ph_n;
        resultLo <= pl_n;
        overflow <= ov_n;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq32.sv
// Directed self-checking bench for mult_seq32.
// Signed vectors run when MULT_SEQ_SIGNED_EN is defined.

module tb_mult_seq32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
`ifdef MULT_SEQ_SIGNED_EN
  logic        sop = 1'b0;
`endif
  logic        busy, done, overflow;
  logic [31:0] resultHi, resultLo;

  int checks = 0;
  int failures = 0;

  mult_seq32 dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
`ifdef MULT_SEQ_SIGNED_EN
    .signedOp (sop),
`endif
    .busy     (busy),
    .done     (done),
    .resultHi (resultHi),
    .resultLo (resultLo),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic eo, input int lat);
    int n;
    @(negedge clock);
    start = 1'b1;
    A = a;
    B = b;
    @(posedge clock);
    #1;
    chk("busy_rise", {63'b0, busy}, 64'd1);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clock);
      A = $urandom;
      B = $urandom;
      start = 1'b1;
      @(posedge clock);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("res_hi", {32'b0, resultHi}, {32'b0, eh});
    chk("res_lo", {32'b0, resultLo}, {32'b0, el});
    chk("ovf", {63'b0, overflow}, {63'b0, eo});
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("idle_back", {62'b0, busy, done}, 64'd0);
    chk("held_lo", {32'b0, resultLo}, {32'b0, el});
  endtask

  initial begin
    int nd;
    int lastd;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out", {busy, done, overflow, resultHi, resultLo},
        67'd0);
    @(negedge clock);
    reset = 1'b0;

    run_mul(32'h0000_1234, 32'h0000_0010, 32'h0, 32'h0001_2340, 1'b0, 32);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b1, 32);
    run_mul(32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 32);
    run_mul(32'h0000_1234, 32'h0000_0010, 32'h0, 32'h0001_2340, 1'b0, 32);

    // reset in the middle of a calculation
    @(negedge clock);
    start = 1'b1;
    A = 32'd5;
    B = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_mid", {busy, done, overflow, resultHi, resultLo}, 67'd0);
    @(negedge clock);
    reset = 1'b0;
    run_mul(32'd5, 32'd7, 32'h0, 32'd35, 1'b0, 32);

    // start held high: one result every 34 cycles
    @(negedge clock);
    A = 32'd3;
    B = 32'd4;
    start = 1'b1;
    @(posedge clock);
    #1;
    nd = 0;
    lastd = 0;
    for (int i = 1; i <= 102; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        nd++;
        chk("tput_lo", {32'b0, resultLo}, 64'd12);
        chk("tput_gap", 64'(i - lastd), (nd == 1) ? 64'd32 : 64'd34);
        lastd = i;
      end
    end
    @(negedge clock);
    start = 1'b0;
    chk("tput_cnt", 64'(nd), 64'd3);
    repeat (40) @(posedge clock);

`ifdef MULT_SEQ_SIGNED_EN
    sop = 1'b1;
    run_mul(32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
    run_mul(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b1, 32);
    sop = 1'b0;
    run_mul(32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1'b1, 32);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_seq32.md
Name: mult_seq32

Overview:
- Iterative 32x32 -> 64-bit multiplier controller.
- Sequences one internal adder32 instance through shift-add steps, one partial product per cycle.
- Sits beside the ALU in the execute stage. The pipeline issues start and stalls on busy until done.
- Only one adder32 is used; there is no combinational multiplier array.

Parameters:
- WIDTH, 32, operand width; only 32 is supported, matching adder32.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  32  multiplicand; captured on the accepted start.
- B  input  32  multiplier; captured on the accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the product is valid.
- resultHi  output  32  upper product word; held until the next accepted start.
- resultLo  output  32  lower product word; held until the next accepted start.
- overflow  output  1  product does not fit in 32 bits; valid with done, held.

Behaviour:
- Reset (synchronous, active-high; clock and reset as named above):
  - Next edge with reset=1: state=IDLE.
  - busy=0, done=0, resultHi=0, resultLo=0, overflow=0.
  - Counter and internal registers M, PH, PL are cleared.
  - Reset overrides everything, including mid-CALC or FIX; a partial product is discarded.
- States: IDLE, CALC, FIX (only with the optional feature), DONE.
- IDLE:
  - start=1 at an edge: M<=A, PH<=0, PL<=B, cnt<=0, next state CALC.
  - busy rises the same edge.
  - start=0: stay in IDLE; outputs hold.
- CALC, each cycle:
  - adder inputs: A=PH, B=(PL[0] ? M : 0), carryIn=0.
  - {PH,PL} <= {carryOut, result, PL} >> 1, i.e. a 65-bit shift right with carryOut entering bit 63.
  - cnt increments.
  - After 32 CALC cycles (cnt==31 at the edge): next state DONE, or FIX if a sign fix is pending.
- DONE (one cycle):
  - done=1, busy=1.
  - resultHi<=PH, resultLo<=PL, overflow computed, all latched at the entry edge.
  - Next state IDLE.
- Latency: start accepted at edge 0; done high in the cycle after edge 32 (unsigned path).
  - The next start is accepted no earlier than the edge that leaves DONE.
  - Throughput: one multiply per 34 cycles.
- start while busy=1: ignored, never queued. A and B changes while busy have no effect.
- Unsigned overflow = (PH != 0).
- Arithmetic is modulo 2^64; carryOut from adder32 is the only carry source.
- The adder overflow output is unused in CALC.

Optional Feature:
- Macro: MULT_SEQ_SIGNED_EN.
- With the macro defined:
  - Extra port: signedOp  input  1, captured with start.
  - signedOp=1 at start:
    - M and PL load |A| and |B| (two's-complement negation on capture; most-negative value 0x80000000 maps to magnitude 0x80000000).
    - neg = A[31]^B[31] is latched.
  - After CALC, if neg=1 and the product is nonzero, state FIX runs 2 cycles using the same adder32:
    - Cycle 1: PL <= ~PL + 1 (carryIn=1, B=0); carry c latched.
    - Cycle 2: PH <= ~PH + 0 with carryIn=c.
    - Then DONE. Signed latency is 34 cycles to done.
  - Signed overflow = PH != {32{PL[31]}}.
  - signedOp=0 behaves exactly as without the macro.
- Without the macro: no signedOp port, no FIX state; all operands are treated unsigned.

Test Plan:
- Reset mid-CALC (start A=5, B=7, reset asserted at cycle 10) -> next edge busy=0, done=0, resultHi=resultLo=0, overflow=0; a later start runs normally.
- Unsigned A=0x0000_1234, B=0x0000_0010 -> done exactly 33 cycles after start; resultHi=0, resultLo=0x0001_2340, overflow=0.
- Unsigned A=B=0xFFFF_FFFF -> resultHi=0xFFFF_FFFE, resultLo=0x0000_0001, overflow=1.
- start pulsed every cycle, A=3, B=4 -> exactly one done per 34 cycles, each with resultLo=12; A/B changes during busy do not alter the result.
- Zero operand A=0, B=0xDEAD_BEEF -> resultHi=resultLo=0, overflow=0, done at the same latency.
- MULT_SEQ_SIGNED_EN, signedOp=1:
  - A=-3 (0xFFFF_FFFD), B=7 -> resultHi=0xFFFF_FFFF, resultLo=0xFFFF_FFEB, overflow=0, done at cycle 35.
  - A=B=0x8000_0000 -> resultHi=0x4000_0000, resultLo=0, overflow=1.
